hazard_stall_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage ARMv8 pipeline. It generates the write-enable and flush controls for PC, IF_ID, ID_EX and EX_MEM. It covers four conditions:
- load-use stalls;
- taken-branch flushes (branch resolved in MEM);
- multi-cycle data-memory waits, using a req/ready handshake with a timeout;
- performance counters.

It sits beside the datapath and drives IF_ID_Write, IF_ID_Flush and the other stage-register controls.

---
 rtl/hazard_stall_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline sequencing controller for the 5-stage ARMv8 pipeline. Produces the
// load enables and clears for PC, IF_ID, ID_EX and EX_MEM from three hazard
// sources (load-use, taken branch resolved in MEM, data-memory wait) and
// keeps saturating performance counters plus a sticky memory-timeout flag.
// The stage controls are combinational so the datapath sees them in the same
// cycle as the hazard; only the wait state machine and counters are stored.

module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic [4:0]       IF_ID_Rn,
    input  logic [4:0]       IF_ID_Rm,
    input  logic             IF_ID_UsesRm,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             EX_MEM_Flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Wait counter just wide enough to hold MEM_TIMEOUT.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic             en);
        logic [CNT_W-1:0] res;
        if (en && (val != {CNT_W{1'b1}})) begin
            res = val + CNT_W'(1);
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              abandon_q, abandon_d;
    logic              mem_error_q, mem_error_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic lu_s;
    logic mf_s;
    logic timeout_s;
    logic flush_evt_s;
    logic pc_write_s;
    logic if_id_write_s;
    logic if_id_flush_s;
    logic id_ex_write_s;
    logic id_ex_flush_s;
    logic ex_mem_write_s;
    logic ex_mem_flush_s;

    // Hazard detection: XZR never creates a dependency; Rm only matters when
    // the instruction in ID actually reads it. A freshly abandoned access is
    // not allowed to freeze the pipeline again on the release cycle.
    always_comb begin
        lu_s = ID_EX_MemRead
             & (ID_EX_Rd != XZR_IDX)
             & ((ID_EX_Rd == IF_ID_Rn) | (IF_ID_UsesRm & (ID_EX_Rd == IF_ID_Rm)));
        mf_s = mem_req & ~mem_ready & ~abandon_q;
    end

    // Next-state and stage-control decode; RUN defaults are assigned first
    // and are also what the pipeline sees while reset is held.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        abandon_d      = 1'b0;
        timeout_s      = 1'b0;
        flush_evt_s    = 1'b0;
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_write_s  = 1'b1;
        id_ex_flush_s  = 1'b0;
        ex_mem_write_s = 1'b1;
        ex_mem_flush_s = 1'b0;
        if (reset) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mf_s) begin
                        // Freeze everything; a coincident branch stays parked
                        // in EX_MEM and is taken after release.
                        pc_write_s     = 1'b0;
                        if_id_write_s  = 1'b0;
                        id_ex_write_s  = 1'b0;
                        ex_mem_write_s = 1'b0;
                        state_d        = ST_MEM_WAIT;
                        wait_cnt_d     = WAIT_W'(1);
                    end else if (branch_taken) begin
                        // Flush kills the younger instructions, so any
                        // load-use hazard among them is moot.
                        if_id_flush_s  = 1'b1;
                        id_ex_flush_s  = 1'b1;
                        ex_mem_flush_s = 1'b1;
                        flush_evt_s    = 1'b1;
                    end else if (lu_s) begin
                        // Hold PC and IF_ID one cycle, bubble into ID_EX.
                        pc_write_s    = 1'b0;
                        if_id_write_s = 1'b0;
                        id_ex_flush_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_write_s  = 1'b0;
                    ex_mem_write_s = 1'b0;
                    if (mem_ready) begin
                        state_d    = ST_RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        // Give up on this access and let the pipeline move on.
                        timeout_s  = 1'b1;
                        abandon_d  = 1'b1;
                        state_d    = ST_RUN;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    // Performance counters and sticky error next-state.
    always_comb begin
        stall_cycles_d = sat_inc(stall_cycles_q, ~pc_write_s & ~reset);
        flush_count_d  = sat_inc(flush_count_q, flush_evt_s);
        mem_error_d    = mem_error_q | timeout_s;
    end

    // State, wait counter, error flag and counters with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            abandon_q      <= 1'b0;
            mem_error_q    <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            abandon_q      <= abandon_d;
            mem_error_q    <= mem_error_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign PC_Write     = pc_write_s;
    assign IF_ID_Write  = if_id_write_s;
    assign IF_ID_Flush  = if_id_flush_s;
    assign ID_EX_Write  = id_ex_write_s;
    assign ID_EX_Flush  = id_ex_flush_s;
    assign EX_MEM_Write = ex_mem_write_s;
    assign EX_MEM_Flush = ex_mem_flush_s;
    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl. Two instances share the stimulus: dut_a
// with default parameters, dut_b with MEM_TIMEOUT=3 and CNT_W=4 for the
// timeout and saturation cases. Each vector names the instance it checks.

module tb_hazard_stall_ctrl;

    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_FRZ  = 7'b0000000;

    typedef struct {
        int         id;
        bit         sel;
        bit         chk;
        bit         rst;
        bit         mr;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
        bit         um;
        bit         br;
        bit         rq;
        bit         rdy;
        logic [6:0] ctrl;
        int         st;
        int         fl;
        bit         er;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset = 1'b1;
    logic       ID_EX_MemRead = 1'b0;
    logic [4:0] ID_EX_Rd = 5'd0;
    logic [4:0] IF_ID_Rn = 5'd0;
    logic [4:0] IF_ID_Rm = 5'd0;
    logic       IF_ID_UsesRm = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;

    logic        a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf, a_err;
    logic [31:0] a_stall, a_flush;
    logic        b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf, b_err;
    logic [3:0]  b_stall, b_flush;

    hazard_stall_ctrl dut_a (
        .clock(clock), .reset(reset),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .IF_ID_Rn(IF_ID_Rn), .IF_ID_Rm(IF_ID_Rm), .IF_ID_UsesRm(IF_ID_UsesRm),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_Write(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_iff),
        .ID_EX_Write(a_idw), .ID_EX_Flush(a_idf),
        .EX_MEM_Write(a_exw), .EX_MEM_Flush(a_exf),
        .mem_error(a_err), .stall_cycles(a_stall), .flush_count(a_flush)
    );

    hazard_stall_ctrl #(.MEM_TIMEOUT(3), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .IF_ID_Rn(IF_ID_Rn), .IF_ID_Rm(IF_ID_Rm), .IF_ID_UsesRm(IF_ID_UsesRm),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_Write(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_iff),
        .ID_EX_Write(b_idw), .ID_EX_Flush(b_idf),
        .EX_MEM_Write(b_exw), .EX_MEM_Flush(b_exf),
        .mem_error(b_err), .stall_cycles(b_stall), .flush_count(b_flush)
    );

    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mkv(input int id, input bit sel, input bit chk, input bit rst,
                                 input bit mr, input logic [4:0] rd, input logic [4:0] rn,
                                 input logic [4:0] rm, input bit um, input bit br,
                                 input bit rq, input bit rdy, input logic [6:0] ctrl,
                                 input int st, input int fl, input bit er);
        vec_t v;
        v.id = id; v.sel = sel; v.chk = chk; v.rst = rst;
        v.mr = mr; v.rd = rd; v.rn = rn; v.rm = rm; v.um = um;
        v.br = br; v.rq = rq; v.rdy = rdy;
        v.ctrl = ctrl; v.st = st; v.fl = fl; v.er = er;
        return v;
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic drive(input vec_t v);
        @(posedge clock);
        #1;
        reset         = v.rst;
        ID_EX_MemRead = v.mr;
        ID_EX_Rd      = v.rd;
        IF_ID_Rn      = v.rn;
        IF_ID_Rm      = v.rm;
        IF_ID_UsesRm  = v.um;
        branch_taken  = v.br;
        mem_req       = v.rq;
        mem_ready     = v.rdy;
        exp_q.push_back(v);
    endtask

    vec_t       cv;
    logic [6:0] got_c;
    int         got_s;
    int         got_f;
    logic       got_e;

    // Scoreboard: pop the expectation for this cycle and compare on the falling edge.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            cv = exp_q.pop_front();
            if (cv.sel == 1'b0) begin
                got_c = {a_pcw, a_ifw, a_iff, a_idw, a_idf, a_exw, a_exf};
                got_s = int'(a_stall);
                got_f = int'(a_flush);
                got_e = a_err;
            end else begin
                got_c = {b_pcw, b_ifw, b_iff, b_idw, b_idf, b_exw, b_exf};
                got_s = int'(b_stall);
                got_f = int'(b_flush);
                got_e = b_err;
            end
            if (cv.chk) begin
                checks++;
                if (got_c !== cv.ctrl) begin
                    errors++;
                    $display("FAIL vec%0d ctrl got %b expected %b", cv.id, got_c, cv.ctrl);
                end
                checks++;
                if (got_s !== cv.st) begin
                    errors++;
                    $display("FAIL vec%0d stall_cycles got %0d expected %0d", cv.id, got_s, cv.st);
                end
                checks++;
                if (got_f !== cv.fl) begin
                    errors++;
                    $display("FAIL vec%0d flush_count got %0d expected %0d", cv.id, got_f, cv.fl);
                end
                checks++;
                if (got_e !== cv.er) begin
                    errors++;
                    $display("FAIL vec%0d mem_error got %b expected %b", cv.id, got_e, cv.er);
                end
            end
        end
    end

    vec_t tbl[22];

    initial begin
        // Single-cycle behaviour on dut_a; counters are cumulative expectations.
        tbl[0]  = mkv(10, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, C_NORM, 0, 0, 0);
        tbl[1]  = mkv(11, 0, 1, 0, 1, 5'd5,  5'd5,  5'd0, 0, 0, 0, 0, C_LU,   0, 0, 0);
        tbl[2]  = mkv(12, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, C_NORM, 1, 0, 0);
        tbl[3]  = mkv(13, 0, 1, 0, 1, 5'd31, 5'd31, 5'd0, 0, 0, 0, 0, C_NORM, 1, 0, 0);
        tbl[4]  = mkv(14, 0, 1, 0, 1, 5'd7,  5'd3,  5'd7, 0, 0, 0, 0, C_NORM, 1, 0, 0);
        tbl[5]  = mkv(15, 0, 1, 0, 1, 5'd7,  5'd3,  5'd7, 1, 0, 0, 0, C_LU,   1, 0, 0);
        tbl[6]  = mkv(16, 0, 1, 0, 1, 5'd5,  5'd5,  5'd0, 0, 1, 0, 0, C_BR,   2, 0, 0);
        tbl[7]  = mkv(17, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, C_NORM, 2, 1, 0);
        tbl[8]  = mkv(18, 0, 1, 0, 0, 5'd5,  5'd5,  5'd0, 0, 0, 0, 0, C_NORM, 2, 1, 0);
        tbl[9]  = mkv(19, 0, 1, 0, 1, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, C_LU,   2, 1, 0);
        tbl[10] = mkv(20, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, C_NORM, 3, 1, 0);
        tbl[11] = mkv(21, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 1, 0, C_FRZ,  3, 1, 0);
        tbl[12] = mkv(22, 0, 1, 0, 1, 5'd5,  5'd5,  5'd0, 0, 0, 1, 0, C_FRZ,  4, 1, 0);
        tbl[13] = mkv(23, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 1, 1, 0, C_FRZ,  5, 1, 0);
        tbl[14] = mkv(24, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 1, 1, 0, C_FRZ,  6, 1, 0);
        tbl[15] = mkv(25, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 1, 1, 1, C_FRZ,  7, 1, 0);
        tbl[16] = mkv(26, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 1, 0, 0, C_BR,   8, 1, 0);
        tbl[17] = mkv(27, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, C_NORM, 8, 2, 0);
        tbl[18] = mkv(28, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 1, 1, 0, C_FRZ,  8, 2, 0);
        tbl[19] = mkv(29, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 1, 1, C_FRZ,  9, 2, 0);
        tbl[20] = mkv(30, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0, C_NORM, 10, 2, 0);
        tbl[21] = mkv(31, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0, 0, 0, 1, 1, C_NORM, 10, 2, 0);

        // Reset: first cycle unchecked (counters unknown), second checks RUN defaults with lu inputs present.
        drive(mkv(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 0, 0, 0));
        drive(mkv(1, 0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, C_NORM, 0, 0, 0));

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
        end

        // Timeout on dut_b (limit 3), sticky error, then reset while dut_a is still waiting.
        drive(mkv(40, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 0, 0, 0));
        drive(mkv(41, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FRZ,  0, 0, 0));
        drive(mkv(42, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FRZ,  1, 0, 0));
        drive(mkv(43, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FRZ,  2, 0, 0));
        drive(mkv(44, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FRZ,  3, 0, 0));
        drive(mkv(45, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_NORM, 4, 0, 1));
        drive(mkv(46, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 4, 0, 1));
        drive(mkv(47, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 4, 0, 1));
        drive(mkv(48, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 7, 0, 0));
        drive(mkv(49, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 0, 0, 0));
        drive(mkv(50, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 0, 0, 0));

        // Stall counter saturation on the 4-bit instance.
        for (int k = 0; k < 20; k++) begin
            drive(mkv(100 + k, 1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, C_LU,
                      (k > 15) ? 15 : k, 0, 0));
        end
        drive(mkv(150, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 15, 0, 0));

        // Flush counter saturation; stall count must not move.
        for (int k = 0; k < 17; k++) begin
            drive(mkv(200 + k, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, C_BR,
                      15, (k > 15) ? 15 : k, 0));
        end
        drive(mkv(250, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 15, 15, 0));

        // Reset asserted in MEM_WAIT: RUN defaults during reset, cleared state after.
        drive(mkv(300, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FRZ,  15, 15, 0));
        drive(mkv(301, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_FRZ,  15, 15, 0));
        drive(mkv(302, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_NORM, 15, 15, 0));
        drive(mkv(303, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM, 0, 0, 0));

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
